// File: rtl/scircuit_seq_ctrl.sv
// Multi-cycle controller/datapath for scircuit2: x = g << lt, z = h >>> eq.
// Define SCTRL_SHARE_ALU_EN for one shared add/sub unit; leave it undefined for three parallel adders.
module scircuit_seq_ctrl #(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] x,
  output logic [DATAWIDTH-1:0] z
);

`ifdef SCTRL_SHARE_ALU_EN
  typedef enum logic [2:0] {IDLE, S_D, S_E, S_F, S_CMP, S_OUT} state_t;
`else
  typedef enum logic [1:0] {IDLE, S_ADD, S_CMP, S_OUT} state_t;
`endif

  state_t state, state_n;

  logic signed [DATAWIDTH-1:0] a_q, b_q, c_q;
  logic signed [DATAWIDTH-1:0] d_q, e_q, f_q;
  logic                        lt_q, eq_q;
  logic signed [DATAWIDTH-1:0] g, h;

  logic capture, ld_cmp, ld_out;
`ifdef SCTRL_SHARE_ALU_EN
  logic                        ld_d, ld_e, ld_f;
  logic                        alu_sub, alu_sel_c;
  logic signed [DATAWIDTH-1:0] alu_rhs, alu_res;
`else
  logic ld_add;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = `ifdef SCTRL_SHARE_ALU_EN S_D `else S_ADD `endif ;
`ifdef SCTRL_SHARE_ALU_EN
      S_D:     state_n = S_E;
      S_E:     state_n = S_F;
      S_F:     state_n = S_CMP;
`else
      S_ADD:   state_n = S_CMP;
`endif
      S_CMP:   state_n = S_OUT;
      S_OUT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath control decoded from the current state
  always_comb begin
    capture = (state == IDLE) && start;
    ld_cmp  = (state == S_CMP);
    ld_out  = (state == S_OUT);
`ifdef SCTRL_SHARE_ALU_EN
    ld_d      = (state == S_D);
    ld_e      = (state == S_E);
    ld_f      = (state == S_F);
    alu_sub   = (state == S_F);
    alu_sel_c = (state == S_E);
`else
    ld_add    = (state == S_ADD);
`endif
  end

`ifdef SCTRL_SHARE_ALU_EN
  assign alu_rhs = alu_sel_c ? c_q : b_q;
  assign alu_res = alu_sub ? DATAWIDTH'(a_q - alu_rhs) : DATAWIDTH'(a_q + alu_rhs);
`endif

  assign g = lt_q ? e_q : d_q;
  assign h = eq_q ? f_q : g;

  // Operands, intermediates and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      d_q  <= '0;
      e_q  <= '0;
      f_q  <= '0;
      lt_q <= 1'b0;
      eq_q <= 1'b0;
      x    <= '0;
      z    <= '0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      busy <= (state_n != IDLE);
      done <= ld_out;
      if (capture) begin
        a_q <= a;
        b_q <= b;
        c_q <= c;
      end
`ifdef SCTRL_SHARE_ALU_EN
      if (ld_d) d_q <= alu_res;
      if (ld_e) e_q <= alu_res;
      if (ld_f) f_q <= alu_res;
`else
      if (ld_add) begin
        d_q <= DATAWIDTH'(a_q + b_q);
        e_q <= DATAWIDTH'(a_q + c_q);
        f_q <= DATAWIDTH'(a_q - b_q);
      end
`endif
      if (ld_cmp) begin
        lt_q <= (d_q < e_q);
        eq_q <= (d_q == e_q);
      end
      if (ld_out) begin
        x <= DATAWIDTH'(g << lt_q);
        z <= DATAWIDTH'(h >>> eq_q);
      end
    end
  end

endmodule
